// File: rtl/memory_access_stage_if.sv
// Data-memory request/ready bus between the memory stage (master) and data memory (slave).
interface memory_access_stage_if;
    logic        memRequest;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic [3:0]  memByteEnable;
    logic        memReady;
    logic [31:0] memReadData;

    modport master (
        output memRequest, memWrite, memAddress, memWriteData, memByteEnable,
        input  memReady, memReadData
    );

    modport slave (
        input  memRequest, memWrite, memAddress, memWriteData, memByteEnable,
        output memReady, memReadData
    );
endinterface

// File: rtl/memory_access_stage.sv
// RISC-V memory stage: branch redirect, load/store lane steering, misalignment and stall control.
// Optional access timeout with busError pulse is enabled by defining MEM_TIMEOUT_EN.
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         valid,
    input  logic [31:0]                  aluResult,
    input  logic [31:0]                  storeData,
    input  logic [2:0]                   funct3,
    input  logic                         memoryReadEnable,
    input  logic                         memoryWriteEnable,
    input  logic                         writeBackFromMemoryOrAlu,
    input  logic                         branch,
    input  logic                         branchEnable,
    input  logic [31:0]                  pcAdder,
    memory_access_stage_if.master        bus,
    output logic                         stall,
    output logic                         pcSelect,
    output logic [31:0]                  branchTarget,
    output logic                         retireValid,
    output logic [31:0]                  writeBackData,
    output logic                         misaligned,
    output logic                         busError
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]  state_reg;
    logic        mem_request_reg;
    logic        mem_write_reg;
    logic [31:0] mem_address_reg;
    logic [31:0] mem_write_data_reg;
    logic [3:0]  mem_byte_enable_reg;
    logic        retire_valid_reg;
    logic [31:0] write_back_data_reg;
    logic        misaligned_reg;
    logic        bus_error_reg;
    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic        wb_from_mem_reg;

    logic        mem_op;
    logic        misalign_detect;
    logic        accept;
    logic        timeout;
    logic [31:0] steer_data_next;
    logic [3:0]  steer_be_next;
    logic [31:0] load_value_next;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign mem_op = memoryReadEnable | memoryWriteEnable;

    // funct3 size decode: 000/100 byte, 001/101 halfword, anything else word
    always_comb begin
        misalign_detect = 1'b0;
        steer_data_next = storeData;
        steer_be_next   = 4'b1111;
        case (funct3)
            3'b000, 3'b100: begin
                steer_data_next = {4{storeData[7:0]}};
                steer_be_next   = 4'b0001 << aluResult[1:0];
            end
            3'b001, 3'b101: begin
                misalign_detect = aluResult[0];
                steer_data_next = {2{storeData[15:0]}};
                steer_be_next   = aluResult[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                misalign_detect = (aluResult[1:0] != 2'b00);
            end
        endcase
    end

    assign accept = (state_reg == IDLE) && valid && mem_op && !misalign_detect;

    always_comb begin
        load_byte       = bus.memReadData[8*addr_reg[1:0] +: 8];
        load_half       = addr_reg[1] ? bus.memReadData[31:16] : bus.memReadData[15:0];
        load_value_next = bus.memReadData;
        case (funct3_reg)
            3'b000:  load_value_next = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_value_next = {24'd0, load_byte};
            3'b001:  load_value_next = {{16{load_half[15]}}, load_half};
            3'b101:  load_value_next = {16'd0, load_half};
            default: load_value_next = bus.memReadData;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] count_reg;

    assign timeout = (state_reg == ACCESS) && (count_reg == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= 8'd0;
        end else if (accept) begin
            count_reg <= 8'd0;
        end else if (state_reg == ACCESS) begin
            count_reg <= count_reg + 8'd1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign stall        = accept || ((state_reg == ACCESS) && !bus.memReady && !timeout);
    assign pcSelect     = valid && branch && branchEnable && (state_reg == IDLE);
    assign branchTarget = pcAdder;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg           <= IDLE;
            mem_request_reg     <= 1'b0;
            mem_write_reg       <= 1'b0;
            mem_address_reg     <= 32'd0;
            mem_write_data_reg  <= 32'd0;
            mem_byte_enable_reg <= 4'd0;
            retire_valid_reg    <= 1'b0;
            write_back_data_reg <= 32'd0;
            misaligned_reg      <= 1'b0;
            bus_error_reg       <= 1'b0;
            addr_reg            <= 32'd0;
            funct3_reg          <= 3'd0;
            wb_from_mem_reg     <= 1'b0;
        end else begin
            misaligned_reg <= 1'b0;
            bus_error_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    retire_valid_reg <= 1'b0;
                    if (valid && mem_op) begin
                        if (misalign_detect) begin
                            misaligned_reg <= 1'b1;
                        end else begin
                            state_reg           <= ACCESS;
                            mem_request_reg     <= 1'b1;
                            mem_write_reg       <= memoryWriteEnable;
                            mem_address_reg     <= {aluResult[31:2], 2'b00};
                            mem_write_data_reg  <= steer_data_next;
                            mem_byte_enable_reg <= memoryWriteEnable ? steer_be_next : 4'b1111;
                            addr_reg            <= aluResult;
                            funct3_reg          <= funct3;
                            wb_from_mem_reg     <= writeBackFromMemoryOrAlu & ~memoryWriteEnable;
                        end
                    end else if (valid) begin
                        retire_valid_reg    <= 1'b1;
                        write_back_data_reg <= aluResult;
                    end
                end
                ACCESS: begin
                    retire_valid_reg <= 1'b0;
                    if (bus.memReady) begin
                        state_reg           <= IDLE;
                        mem_request_reg     <= 1'b0;
                        mem_write_reg       <= 1'b0;
                        mem_byte_enable_reg <= 4'd0;
                        retire_valid_reg    <= 1'b1;
                        write_back_data_reg <= wb_from_mem_reg ? load_value_next : addr_reg;
                    end else if (timeout) begin
                        state_reg           <= IDLE;
                        mem_request_reg     <= 1'b0;
                        mem_write_reg       <= 1'b0;
                        mem_byte_enable_reg <= 4'd0;
                        bus_error_reg       <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.memRequest    = mem_request_reg;
    assign bus.memWrite      = mem_write_reg;
    assign bus.memAddress    = mem_address_reg;
    assign bus.memWriteData  = mem_write_data_reg;
    assign bus.memByteEnable = mem_byte_enable_reg;
    assign retireValid       = retire_valid_reg;
    assign writeBackData     = write_back_data_reg;
    assign misaligned        = misaligned_reg;
    assign busError          = bus_error_reg;
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage; inputs change and outputs are sampled on the falling edge.
module tb_memory_access_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] aluResult;
    logic [31:0] storeData;
    logic [2:0]  funct3;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic        writeBackFromMemoryOrAlu;
    logic        branch;
    logic        branchEnable;
    logic [31:0] pcAdder;
    logic        stall;
    logic        pcSelect;
    logic [31:0] branchTarget;
    logic        retireValid;
    logic [31:0] writeBackData;
    logic        misaligned;
    logic        busError;

    int total = 0;
    int bad   = 0;
    int stall_cycles;

    memory_access_stage_if bus();

    memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock),
        .reset(reset),
        .valid(valid),
        .aluResult(aluResult),
        .storeData(storeData),
        .funct3(funct3),
        .memoryReadEnable(memoryReadEnable),
        .memoryWriteEnable(memoryWriteEnable),
        .writeBackFromMemoryOrAlu(writeBackFromMemoryOrAlu),
        .branch(branch),
        .branchEnable(branchEnable),
        .pcAdder(pcAdder),
        .bus(bus),
        .stall(stall),
        .pcSelect(pcSelect),
        .branchTarget(branchTarget),
        .retireValid(retireValid),
        .writeBackData(writeBackData),
        .misaligned(misaligned),
        .busError(busError)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic [31:0] a, input logic [31:0] sd,
                           input logic [2:0] f3, input logic rd, input logic wr, input logic wbm);
        valid                    = v;
        aluResult                = a;
        storeData                = sd;
        funct3                   = f3;
        memoryReadEnable         = rd;
        memoryWriteEnable        = wr;
        writeBackFromMemoryOrAlu = wbm;
    endtask

    task automatic idle_inputs();
        present(1'b0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Runs a one-wait-free memory access from accept to retire and checks the retired value.
    task automatic zero_wait(input string tag, input logic [31:0] rdata, input logic [31:0] exp_wb);
        @(negedge clock);
        idle_inputs();
        bus.memReady    = 1'b1;
        bus.memReadData = rdata;
        @(negedge clock);
        bus.memReady = 1'b0;
        check({tag, "_retire"}, {31'd0, retireValid}, 32'd1);
        check({tag, "_wb"}, writeBackData, exp_wb);
        $display("txn %s wb=%h", tag, writeBackData);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        branch = 1'b0; branchEnable = 1'b0; pcAdder = 32'd0;
        bus.memReady = 1'b0; bus.memReadData = 32'd0;
        repeat (2) @(negedge clock);
        check("rst_req", {31'd0, bus.memRequest}, 32'd0);
        check("rst_addr", bus.memAddress, 32'd0);
        check("rst_be", {28'd0, bus.memByteEnable}, 32'd0);
        check("rst_retire", {31'd0, retireValid}, 32'd0);
        check("rst_wb", writeBackData, 32'd0);
        check("rst_err", {30'd0, misaligned, busError}, 32'd0);
        reset = 1'b0;
        $display("txn reset done");

        // ALU op
        @(negedge clock);
        present(1'b1, 32'h1234, 32'd0, 3'b010, 1'b0, 1'b0, 1'b0);
        #1 check("alu_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        idle_inputs();
        check("alu_retire", {31'd0, retireValid}, 32'd1);
        check("alu_wb", writeBackData, 32'h1234);
        $display("txn alu wb=%h", writeBackData);
        @(negedge clock);
        check("alu_noretire", {31'd0, retireValid}, 32'd0);

        // LB 0x103 zero-wait
        present(1'b1, 32'h103, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1);
        #1 check("lb_stallN", {31'd0, stall}, 32'd1);
        @(negedge clock);
        idle_inputs();
        check("lb_req", {31'd0, bus.memRequest}, 32'd1);
        check("lb_addr", bus.memAddress, 32'h100);
        check("lb_wr", {31'd0, bus.memWrite}, 32'd0);
        bus.memReady = 1'b1; bus.memReadData = 32'h80FF_FF00;
        #1 check("lb_stall_ready", {31'd0, stall}, 32'd0);
        @(negedge clock);
        bus.memReady = 1'b0;
        check("lb_retire", {31'd0, retireValid}, 32'd1);
        check("lb_wb", writeBackData, 32'hFFFF_FF80);
        check("lb_req_drop", {31'd0, bus.memRequest}, 32'd0);
        $display("txn lb wb=%h", writeBackData);

        // SH 0x202, memReady five cycles late
        present(1'b1, 32'h202, 32'hAAAA_BEEF, 3'b001, 1'b0, 1'b1, 1'b0);
        stall_cycles = 0;
        #1 if (stall) stall_cycles++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            idle_inputs();
            #1;
            check("sh_req", {31'd0, bus.memRequest}, 32'd1);
            check("sh_wr", {31'd0, bus.memWrite}, 32'd1);
            check("sh_be", {28'd0, bus.memByteEnable}, 32'hC);
            check("sh_wdata", bus.memWriteData, 32'hBEEF_BEEF);
            if (stall) stall_cycles++;
        end
        @(negedge clock);
        bus.memReady = 1'b1;
        #1 if (stall) stall_cycles++;
        check("sh_stall_cycles", stall_cycles, 32'd6);
        @(negedge clock);
        bus.memReady = 1'b0;
        check("sh_retire", {31'd0, retireValid}, 32'd1);
        check("sh_wb", writeBackData, 32'h202);
        $display("txn sh wb=%h stall_cycles=%0d", writeBackData, stall_cycles);

        // LW misaligned
        present(1'b1, 32'h005, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1);
        #1 check("lw_mis_stall", {31'd0, stall}, 32'd0);
        @(negedge clock);
        idle_inputs();
        check("lw_mis_pulse", {31'd0, misaligned}, 32'd1);
        check("lw_mis_req", {31'd0, bus.memRequest}, 32'd0);
        check("lw_mis_retire", {31'd0, retireValid}, 32'd0);
        @(negedge clock);
        check("lw_mis_once", {31'd0, misaligned}, 32'd0);
        $display("txn lw misaligned");

        // Branch
        present(1'b1, 32'h55, 32'd0, 3'b000, 1'b0, 1'b0, 1'b0);
        branch = 1'b1; branchEnable = 1'b1; pcAdder = 32'h400;
        #1 check("br_sel", {31'd0, pcSelect}, 32'd1);
        check("br_target", branchTarget, 32'h400);
        branchEnable = 1'b0;
        #1 check("br_notaken", {31'd0, pcSelect}, 32'd0);
        @(negedge clock);
        branch = 1'b0;
        $display("txn branch target=%h", branchTarget);

        // LHU / LH / unselected memory write-back / SB / SW / store priority
        present(1'b1, 32'h002, 32'd0, 3'b101, 1'b1, 1'b0, 1'b1);
        zero_wait("lhu", 32'h8001_7F00, 32'h0000_8001);
        present(1'b1, 32'h002, 32'd0, 3'b001, 1'b1, 1'b0, 1'b1);
        zero_wait("lh", 32'h8001_7F00, 32'hFFFF_8001);
        present(1'b1, 32'h044, 32'd0, 3'b100, 1'b1, 1'b0, 1'b0);
        zero_wait("lbu_alu", 32'h1122_3344, 32'h044);
        present(1'b1, 32'h001, 32'h1234_56A5, 3'b000, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        check("sb_be", {28'd0, bus.memByteEnable}, 32'h2);
        check("sb_wdata", bus.memWriteData, 32'hA5A5_A5A5);
        bus.memReady = 1'b1;
        @(negedge clock);
        bus.memReady = 1'b0;
        present(1'b1, 32'h010, 32'hCAFE_F00D, 3'b010, 1'b1, 1'b1, 1'b1);
        @(negedge clock);
        check("sw_prio_wr", {31'd0, bus.memWrite}, 32'd1);
        check("sw_be", {28'd0, bus.memByteEnable}, 32'hF);
        check("sw_wdata", bus.memWriteData, 32'hCAFE_F00D);
        idle_inputs();
        bus.memReady = 1'b1; bus.memReadData = 32'hDEAD_BEEF;
        @(negedge clock);
        check("sw_wb_addr", writeBackData, 32'h010);
        $display("txn sw wb=%h", writeBackData);

        // memReady while IDLE is ignored
        @(negedge clock);
        check("idle_ready_retire", {31'd0, retireValid}, 32'd0);
        check("idle_ready_req", {31'd0, bus.memRequest}, 32'd0);
        bus.memReady = 1'b0;

        // Reset mid-ACCESS, then a late memReady
        present(1'b1, 32'h020, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1);
        @(negedge clock);
        idle_inputs();
        check("rstmid_req_before", {31'd0, bus.memRequest}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rstmid_req_after", {31'd0, bus.memRequest}, 32'd0);
        bus.memReady = 1'b1;
        @(negedge clock);
        bus.memReady = 1'b0;
        check("rstmid_late_ready", {31'd0, retireValid}, 32'd0);
        $display("txn reset mid-access");

`ifdef MEM_TIMEOUT_EN
        present(1'b1, 32'h030, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            idle_inputs();
            #1 check("to_wait_stall", {31'd0, stall}, 32'd1);
            check("to_wait_err", {31'd0, busError}, 32'd0);
        end
        @(negedge clock);
        #1 check("to_last_stall", {31'd0, stall}, 32'd0);
        check("to_last_req", {31'd0, bus.memRequest}, 32'd1);
        @(negedge clock);
        check("to_err", {31'd0, busError}, 32'd1);
        check("to_req_drop", {31'd0, bus.memRequest}, 32'd0);
        check("to_retire", {31'd0, retireValid}, 32'd0);
        @(negedge clock);
        check("to_err_once", {31'd0, busError}, 32'd0);
        $display("txn timeout");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
